// File: rtl/alu_exec_pkg.sv
// Shared opcode codes and small decode helpers for the ALU execute stage.
// The codes mirror the operand-decode opcode set, so decode and execute agree.
package alu_exec_pkg;

   localparam int OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_LSL = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_LSR = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_ASR = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_CSL = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_CSR = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_AND = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_OR  = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_XOR = 4'h9;

   // True for opcodes that produce a value for writeback; NOP and any
   // undefined code still consume an input slot but never raise out_valid.
   function automatic logic is_result_op(input logic [OPCODE_W-1:0] op);
      logic r;
      r = 1'b0;
      case (op)
         OP_ADD, OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR,
         OP_AND, OP_OR, OP_XOR: r = 1'b1;
         default:               r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for the five shift/rotate opcodes.
// Linear shifts saturate when the amount reaches the word width; rotates use
// only the low log2(WORD_WIDTH) bits of the amount.
module alu_shifter
   import alu_exec_pkg::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic [WORD_WIDTH-1:0] a,
   input  logic [WORD_WIDTH-1:0] b,
   input  logic [OPCODE_W-1:0]   opcode,
   output logic [WORD_WIDTH-1:0] shifted
);

   localparam int SHAMT_W = $clog2(WORD_WIDTH);

   logic [SHAMT_W-1:0]      shamt;
   logic                    out_of_range;
   logic [WORD_WIDTH-1:0]   sign_fill;
   logic [2*WORD_WIDTH-1:0] doubled;
   logic [2*WORD_WIDTH-1:0] rot_left_wide;
   logic [2*WORD_WIDTH-1:0] rot_right_wide;

   assign shamt        = b[SHAMT_W-1:0];
   // Any set bit above the low field means the amount is >= WORD_WIDTH.
   assign out_of_range = |b[WORD_WIDTH-1:SHAMT_W];
   assign sign_fill    = {WORD_WIDTH{a[WORD_WIDTH-1]}};

   // Rotation is a shift of the word concatenated with itself; the wanted
   // word then falls out of the upper (left) or lower (right) half.
   assign doubled        = {a, a};
   assign rot_left_wide  = doubled << shamt;
   assign rot_right_wide = doubled >> shamt;

   // Select the shift flavour and apply the out-of-range saturation rules.
   always_comb begin
      shifted = '0;
      case (opcode)
         OP_LSL:  shifted = out_of_range ? '0 : (a << shamt);
         OP_LSR:  shifted = out_of_range ? '0 : (a >> shamt);
         OP_ASR:  shifted = out_of_range ? sign_fill
                                         : WORD_WIDTH'($signed(a) >>> shamt);
         OP_CSL:  shifted = rot_left_wide[2*WORD_WIDTH-1:WORD_WIDTH];
         OP_CSR:  shifted = rot_right_wide[WORD_WIDTH-1:0];
         default: shifted = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: adder, logic ops and shifter feeding a single result
// register with valid/ready handshaking and flush, plus the architectural
// carry and overflow flags. WORD_WIDTH must be a power of two, >= 8.
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] alu_a,
   input  logic [WORD_WIDTH-1:0] alu_b,
   input  logic                  alu_ic,
   input  logic [OPCODE_W-1:0]   alu_opcode,
   input  logic                  store_carry,
   input  logic                  store_overflow,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] result,
   output logic                  carry,
   output logic                  overflow
);

   localparam int MSB = WORD_WIDTH - 1;

   logic                  accept;
   logic                  commit;
   logic                  drain;
   logic                  is_add;
   logic [WORD_WIDTH:0]   sum;
   logic                  add_carry;
   logic                  add_overflow;
   logic [WORD_WIDTH-1:0] shift_word;
   logic [WORD_WIDTH-1:0] result_next;
   logic                  out_valid_next;

   // The slot is free when empty or when writeback takes the held value this
   // same cycle, so back-to-back bundles stream without a bubble.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;
   // A flush kills the bundle being accepted alongside it, flags included.
   assign commit   = accept && !flush;
   assign is_add   = (alu_opcode == OP_ADD);

   // Full-width sum with the carry-out as the extra top bit.
   assign sum          = {1'b0, alu_a} + {1'b0, alu_b} + {{WORD_WIDTH{1'b0}}, alu_ic};
   assign add_carry    = sum[WORD_WIDTH];
   assign add_overflow = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);

   alu_shifter #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_shifter (
      .a       (alu_a),
      .b       (alu_b),
      .opcode  (alu_opcode),
      .shifted (shift_word)
   );

   // Result mux across adder, shifter and bitwise ops.
   always_comb begin
      result_next = '0;
      case (alu_opcode)
         OP_ADD:                                 result_next = sum[WORD_WIDTH-1:0];
         OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR: result_next = shift_word;
         OP_AND:                                 result_next = alu_a & alu_b;
         OP_OR:                                  result_next = alu_a | alu_b;
         OP_XOR:                                 result_next = alu_a ^ alu_b;
         default:                                result_next = '0;
      endcase
   end

   // Occupancy of the result register: flush wins, an accepted NOP leaves the
   // slot empty, otherwise a drained slot empties and a stalled one holds.
   always_comb begin
      out_valid_next = out_valid;
      if (flush) begin
         out_valid_next = 1'b0;
      end else if (accept) begin
         out_valid_next = is_result_op(alu_opcode);
      end else if (drain) begin
         out_valid_next = 1'b0;
      end
   end

   // Output register; the value only changes when a live result is committed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
      end else begin
         out_valid <= out_valid_next;
         if (commit && is_result_op(alu_opcode)) begin
            result <= result_next;
         end
      end
   end

   // Architectural flags: only a committed ADD with the matching store bit
   // updates them; flush never rolls back earlier updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (commit && is_add) begin
         if (store_carry) begin
            carry <= add_carry;
         end
         if (store_overflow) begin
            overflow <= add_overflow;
         end
      end
   end

endmodule
